// File: rtl/render_pkg.sv
// Shared definitions for the render_* family of frame renderers.
//
// Contents:
//   render_state_e  frame-render state machine encoding
//   next_cidx()     advance a colour index by one, wrapping and skipping the background index
//                   (indices up to 8 bits wide)
package render_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT_CLR,
        CLEAR,
        INIT_RECT,
        DRAW,
        MOVE,
        DONE
    } render_state_e;

    // Next colour index modulo 2^width, never landing on the background index.
    function automatic logic [7:0] next_cidx(input logic [7:0] cur, input logic [7:0] bg,
                                             input int unsigned width);
        logic [7:0] mask;
        logic [7:0] nxt;
        mask = 8'((1 << width) - 1);
        nxt  = (cur + 8'd1) & mask;
        if (nxt == (bg & mask)) begin
            nxt = (nxt + 8'd1) & mask;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/draw_rect_scan.sv
// Raster scanner for an axis-aligned rectangle window (x fastest, one pixel per cycle).
// Used for both the full-screen clear and the rectangle fill.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           load window (x0,y0)..(x1,y1); ignored while busy
//   oe              output enable; low holds the scan position
//   x0, y0, x1, y1  window corners (inclusive), sampled on start
//   x, y            current pixel coordinate
//   drawing         x/y valid this cycle (busy && oe)
//   busy            scan in progress
//   done            high on the cycle the last pixel (x1,y1) is emitted
module draw_rect_scan #(
    parameter int unsigned CORDW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    oe,
    input  logic signed [CORDW-1:0] x0,
    input  logic signed [CORDW-1:0] y0,
    input  logic signed [CORDW-1:0] x1,
    input  logic signed [CORDW-1:0] y1,
    output logic signed [CORDW-1:0] x,
    output logic signed [CORDW-1:0] y,
    output logic                    drawing,
    output logic                    busy,
    output logic                    done
);

    logic signed [CORDW-1:0] x_q, y_q;
    logic signed [CORDW-1:0] x0_q, x1_q, y1_q;
    logic                    busy_q;
    logic                    at_row_end;
    logic                    at_last;

    assign at_row_end = (x_q == x1_q);
    assign at_last    = at_row_end && (y_q == y1_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            x0_q   <= '0;
            x1_q   <= '0;
            y1_q   <= '0;
            busy_q <= 1'b0;
        end else if (start && !busy_q) begin
            x_q    <= x0;
            y_q    <= y0;
            x0_q   <= x0;
            x1_q   <= x1;
            y1_q   <= y1;
            busy_q <= 1'b1;
        end else if (busy_q && oe) begin
            if (at_last) begin
                // Coordinates stay on the final pixel once the scan ends.
                busy_q <= 1'b0;
            end else if (at_row_end) begin
                x_q <= x0_q;
                y_q <= y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign busy    = busy_q;
    assign drawing = busy_q && oe;
    assign done    = busy_q && oe && at_last;

endmodule

// File: rtl/render_bounce_rect.sv
// Animated frame renderer: on each start pulse, clears the framebuffer to BG_CIDX, fills one
// rectangle at its current position, then moves the rectangle with edge bounce.
//
// Optional feature (macro RENDER_BOUNCE_COLR_EN): every move that reverses direction on either
// axis advances the rectangle colour index modulo 2^CIDXW, skipping BG_CIDX (resets to FG_CIDX).
// Without the macro the rectangle is always FG_CIDX.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   oe         output enable; low stalls drawing
//   start      begin a frame render (accepted only when idle)
//   x, y       signed draw coordinate
//   cidx       colour index of the current pixel
//   drawing    x/y/cidx valid this cycle
//   done       one-cycle pulse when a frame render completes
module render_bounce_rect
    import render_pkg::*;
#(
    parameter int unsigned CORDW     = 16,
    parameter int unsigned CIDXW     = 2,
    parameter int unsigned SCALE     = 1,
    parameter int unsigned FB_WIDTH  = 160,
    parameter int unsigned FB_HEIGHT = 90,
    parameter int unsigned RECT_W    = 20,
    parameter int unsigned RECT_H    = 12,
    parameter int          INIT_X    = 0,
    parameter int          INIT_Y    = 0,
    parameter int unsigned SPEED     = 1,
    parameter int unsigned BG_CIDX   = 0,
    parameter int unsigned FG_CIDX   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    oe,
    input  logic                    start,
    output logic signed [CORDW-1:0] x,
    output logic signed [CORDW-1:0] y,
    output logic [CIDXW-1:0]        cidx,
    output logic                    drawing,
    output logic                    done
);

    localparam logic signed [CORDW-1:0] ZERO   = '0;
    localparam logic signed [CORDW-1:0] ONE    = CORDW'(1);
    localparam logic signed [CORDW-1:0] W_S    = CORDW'(FB_WIDTH * SCALE);
    localparam logic signed [CORDW-1:0] H_S    = CORDW'(FB_HEIGHT * SCALE);
    localparam logic signed [CORDW-1:0] RW_S   = CORDW'(RECT_W * SCALE);
    localparam logic signed [CORDW-1:0] RH_S   = CORDW'(RECT_H * SCALE);
    localparam logic signed [CORDW-1:0] SPD_S  = CORDW'(SPEED);
    localparam logic signed [CORDW-1:0] INIT_PX = CORDW'(INIT_X * SCALE);
    localparam logic signed [CORDW-1:0] INIT_PY = CORDW'(INIT_Y * SCALE);
    // Largest legal top-left coordinate per axis; <= 0 when the rectangle is too big.
    localparam logic signed [CORDW-1:0] LIM_X  = W_S - RW_S;
    localparam logic signed [CORDW-1:0] LIM_Y  = H_S - RH_S;

    render_state_e           state_q, state_d;
    logic signed [CORDW-1:0] px_q, px_d, py_q, py_d;
    logic                    dx_q, dx_d, dy_q, dy_d;  // 1 = moving toward smaller coordinates
    logic [CIDXW-1:0]        cidx_q, cidx_d;
    logic                    done_q;
    logic [CIDXW-1:0]        rect_cidx;

    logic                    scan_start;
    logic signed [CORDW-1:0] win_x0, win_y0, win_x1, win_y1;
    logic signed [CORDW-1:0] scan_x, scan_y;
    logic                    scan_drawing, scan_busy, scan_done;

    // Returns {reverse_flag, new_position} for one axis.
    function automatic logic [CORDW:0] bounce_axis(input logic signed [CORDW-1:0] p,
                                                   input logic neg,
                                                   input logic signed [CORDW-1:0] lim);
        logic signed [CORDW-1:0] nx;
        nx = neg ? (p - SPD_S) : (p + SPD_S);
        if (nx <= ZERO || lim <= ZERO) begin
            return {1'b0, ZERO};
        end else if (nx >= lim) begin
            return {1'b1, lim};
        end else begin
            return {neg, nx};
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        px_d       = px_q;
        py_d       = py_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        cidx_d     = cidx_q;
        scan_start = 1'b0;
        win_x0     = ZERO;
        win_y0     = ZERO;
        win_x1     = W_S - ONE;
        win_y1     = H_S - ONE;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = INIT_CLR;
            end
            INIT_CLR: begin
                scan_start = 1'b1;
                cidx_d     = CIDXW'(BG_CIDX);
                state_d    = CLEAR;
            end
            CLEAR: begin
                // !scan_busy only guards against a scan that never reports its last pixel.
                if (scan_done || !scan_busy) state_d = INIT_RECT;
            end
            INIT_RECT: begin
                scan_start = 1'b1;
                win_x0     = px_q;
                win_y0     = py_q;
                win_x1     = px_q + RW_S - ONE;
                win_y1     = py_q + RH_S - ONE;
                cidx_d     = rect_cidx;
                state_d    = DRAW;
            end
            DRAW: begin
                if (scan_done || !scan_busy) state_d = MOVE;
            end
            MOVE: begin
                {dx_d, px_d} = bounce_axis(px_q, dx_q, LIM_X);
                {dy_d, py_d} = bounce_axis(py_q, dy_q, LIM_Y);
                state_d      = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            px_q    <= INIT_PX;
            py_q    <= INIT_PY;
            dx_q    <= 1'b0;
            dy_q    <= 1'b0;
            cidx_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            cidx_q  <= cidx_d;
            done_q  <= (state_q == DONE);
        end
    end

`ifdef RENDER_BOUNCE_COLR_EN
    logic [CIDXW-1:0] rect_cidx_q, rect_cidx_d;
    logic             reversal;

    assign reversal = (state_q == MOVE) && ((dx_d != dx_q) || (dy_d != dy_q));

    always_comb begin
        rect_cidx_d = rect_cidx_q;
        if (reversal) begin
            rect_cidx_d = CIDXW'(next_cidx(8'(rect_cidx_q), 8'(BG_CIDX), CIDXW));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rect_cidx_q <= CIDXW'(FG_CIDX);
        end else begin
            rect_cidx_q <= rect_cidx_d;
        end
    end

    assign rect_cidx = rect_cidx_q;
`else
    assign rect_cidx = CIDXW'(FG_CIDX);
`endif

    draw_rect_scan #(
        .CORDW (CORDW)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .start   (scan_start),
        .oe      (oe),
        .x0      (win_x0),
        .y0      (win_y0),
        .x1      (win_x1),
        .y1      (win_y1),
        .x       (scan_x),
        .y       (scan_y),
        .drawing (scan_drawing),
        .busy    (scan_busy),
        .done    (scan_done)
    );

    assign x       = scan_x;
    assign y       = scan_y;
    assign cidx    = cidx_q;
    assign drawing = scan_drawing;
    assign done    = done_q;

endmodule
